// File: rtl/mont_final_reduce.sv
// -----------------------------------------------------------------------------
// mont_final_reduce
//
// Final conditional subtraction behind the 1024-bit Montgomery multiplier.
// Takes the unreduced product T (T < 2M) and returns T mod M in [0, M).
//
// D = T - M is computed one WORD_W slice per cycle with a rippling borrow.
// The borrow out of the top slice picks the answer: borrow=1 means T < M,
// so T is already reduced; otherwise D is the residue.
//
// Optional build macro: FINAL_REDUCE_CHECK_EN
//   Adds an 'err' output. A second borrow chain computes E = D - M in the
//   same slice cycles. err=1 at done means T >= 2M, which breaks the
//   input contract. result is selected the same way whether or not err is set.
//
// Ports
//   clk     in   rising-edge clock
//   resetn  in   synchronous reset, active HIGH (1 = reset)
//   start   in   one-cycle request, only looked at in IDLE
//   in_t    in   [DATA_W:0]   unreduced product
//   in_m    in   [DATA_W-1:0] modulus
//   result  out  [DATA_W-1:0] reduced value, held between jobs
//   done    out  one-cycle pulse when result is valid
//   busy    out  high while slices are being subtracted
//   err     out  (FINAL_REDUCE_CHECK_EN only) T >= 2M detected
//
// Timing: start sampled at edge k. Slices are processed on edges k+1..k+NW.
// done is high in the cycle after edge k+NW+1. busy is high for NW cycles.
// -----------------------------------------------------------------------------
module mont_final_reduce #(
    parameter int DATA_W = 1024,
    parameter int WORD_W = 128
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [DATA_W:0]   in_t,
    input  logic [DATA_W-1:0] in_m,
    output logic [DATA_W-1:0] result,
    output logic              done,
`ifdef FINAL_REDUCE_CHECK_EN
    output logic              err,
`endif
    output logic              busy
);

    localparam int NW    = (DATA_W + 1 + WORD_W - 1) / WORD_W;
    localparam int EXT_W = NW * WORD_W;
    localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {IDLE, SUB, FIN} state_t;

    state_t                       state;
    logic [CNT_W-1:0]             cnt;
    logic                         borrow;
    logic [NW-1:0][WORD_W-1:0]    t_q;
    logic [NW-1:0][WORD_W-1:0]    m_q;
    logic [NW-1:0][WORD_W-1:0]    d_q;

    // Current slice subtraction. The extra top bit of d_ext is the borrow out:
    // both operands are below 2^WORD_W, so a negative difference always
    // leaves that bit set.
    logic [WORD_W-1:0] t_s, m_s;
    logic [WORD_W:0]   d_ext;

    assign t_s   = t_q[cnt];
    assign m_s   = m_q[cnt];
    assign d_ext = {1'b0, t_s} - {1'b0, m_s} - (WORD_W+1)'(borrow);

    // Flat views, used to take the low DATA_W bits at FIN
    logic [EXT_W-1:0] t_flat, d_flat;
    assign t_flat = t_q;
    assign d_flat = d_q;

`ifdef FINAL_REDUCE_CHECK_EN
    // Second chain: E = D - M, fed by the D slice produced this same cycle
    logic            borrow2;
    logic [WORD_W:0] e_ext;
    assign e_ext = {1'b0, d_ext[WORD_W-1:0]} - {1'b0, m_s} - (WORD_W+1)'(borrow2);
`endif

    // Padding bits above DATA_W take part only in the borrow chain
    logic unused_hi;
`ifdef FINAL_REDUCE_CHECK_EN
    assign unused_hi = ^{t_flat[EXT_W-1:DATA_W], d_flat[EXT_W-1:DATA_W], e_ext[WORD_W-1:0]};
`else
    assign unused_hi = ^{t_flat[EXT_W-1:DATA_W], d_flat[EXT_W-1:DATA_W]};
`endif

    always_ff @(posedge clk) begin
        if (resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            borrow <= 1'b0;
            t_q    <= '0;
            m_q    <= '0;
            d_q    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
`ifdef FINAL_REDUCE_CHECK_EN
            borrow2 <= 1'b0;
            err     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        t_q    <= EXT_W'(in_t);
                        m_q    <= EXT_W'(in_m);
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SUB;
`ifdef FINAL_REDUCE_CHECK_EN
                        borrow2 <= 1'b0;
`endif
                    end
                end

                SUB: begin
                    d_q[cnt] <= d_ext[WORD_W-1:0];
                    borrow   <= d_ext[WORD_W];
`ifdef FINAL_REDUCE_CHECK_EN
                    borrow2  <= e_ext[WORD_W];
`endif
                    if (cnt == CNT_W'(NW - 1)) begin
                        busy  <= 1'b0;
                        state <= FIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                FIN: begin
                    // Two cycles here. The first registers result and done.
                    // The second is the done cycle; start stays ignored there,
                    // which gives one IDLE cycle before the next job can start.
                    if (!done) begin
                        result <= borrow ? t_flat[DATA_W-1:0] : d_flat[DATA_W-1:0];
                        done   <= 1'b1;
`ifdef FINAL_REDUCE_CHECK_EN
                        err    <= ~borrow & ~borrow2;
`endif
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_final_reduce.sv
module tb_mont_final_reduce;

    localparam int DATA_W   = 1024;
    localparam int WORD_W   = 128;
    localparam int LAT      = 10;   // start edge to done-visible edge
    localparam int BUSY_CYC = 9;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic              start = 1'b0;
    logic [DATA_W:0]   in_t = '0;
    logic [DATA_W-1:0] in_m = '0;
    logic [DATA_W-1:0] result;
    logic              done, busy;
`ifdef FINAL_REDUCE_CHECK_EN
    logic              err;
`endif

    mont_final_reduce #(.DATA_W(DATA_W), .WORD_W(WORD_W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .in_t(in_t), .in_m(in_m),
        .result(result), .done(done),
`ifdef FINAL_REDUCE_CHECK_EN
        .err(err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATA_W:0]   t;
        logic [DATA_W-1:0] m;
        logic [DATA_W-1:0] r;
        logic              e;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] r;
        logic              e;
        int                due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk_wide(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got hi=%h lo=%h want hi=%h lo=%h", name,
                     act[DATA_W-1:DATA_W-64], act[63:0], exp[DATA_W-1:DATA_W-64], exp[63:0]);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference: plain wide compare-and-subtract
    function automatic vec_t mk(input logic [DATA_W:0] t, input logic [DATA_W-1:0] m);
        vec_t v;
        logic [DATA_W:0] m1, d, e;
        m1  = {1'b0, m};
        v.t = t;
        v.m = m;
        d   = (t >= m1) ? t - m1 : t;
        v.r = d[DATA_W-1:0];
        v.e = (t >= m1) && ((t - m1) >= m1);
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] rnd_wide();
        logic [DATA_W-1:0] x;
        for (int i = 0; i < DATA_W / 32; i++) x[i*32 +: 32] = $urandom;
        return x;
    endfunction

    // Drive one job and wait for its done.
    // poke_at >= 0: pulse start with junk T that many cycles into SUB.
    // poke_done: pulse start again in the done cycle.
    task automatic run_job(input vec_t v, input string name, input int poke_at, input bit poke_done);
        exp_t x;
        int   n, bc;
        @(negedge clk);
        in_t  = v.t;
        in_m  = v.m;
        start = 1'b1;
        x.r   = v.r;
        x.e   = v.e;
        x.due = cyc + 1 + LAT;
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
        in_t  = '1;              // don't-care after capture
        n = 0;
        bc = 0;
        while (n < 30) begin
            if (done) break;
            if (busy) bc++;
            start = (n == poke_at);
            if (n == poke_at) in_t = {1'b0, rnd_wide()};
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done want done", name);
            void'(sb.pop_front());
        end else begin
            x = sb.pop_front();
            chk_wide({name, "_result"}, result, x.r);
            chk_int({name, "_latency"}, cyc, x.due);
            chk_int({name, "_busy_cycles"}, bc, BUSY_CYC);
`ifdef FINAL_REDUCE_CHECK_EN
            chk_int({name, "_err"}, int'(err), int'(x.e));
`endif
            if (poke_done) begin
                start = 1'b1;
                in_t  = {1'b0, rnd_wide()};
            end
            @(negedge clk);
            start = 1'b0;
            chk_int({name, "_done_width"}, int'(done), 0);
        end
    endtask

    // No done and no busy for a window
    task automatic quiet(input string name, input int cycles);
        int dn, bn;
        dn = 0;
        bn = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) dn++;
            if (busy) bn++;
        end
        chk_int({name, "_no_done"}, dn, 0);
        chk_int({name, "_no_busy"}, bn, 0);
    endtask

    vec_t              vt[10];
    logic [DATA_W-1:0] m0, mr, r;
    logic [DATA_W:0]   t1;

    initial begin
        m0 = '0;
        m0[DATA_W-1] = 1'b1;
        m0[0] = 1'b1;                       // M = 2^1023 + 1
        mr = rnd_wide();
        mr[DATA_W-1] = 1'b1;
        mr[0] = 1'b1;
        r = rnd_wide();
        r[DATA_W-1] = 1'b0;                 // r < mr

        t1 = '0;
        t1[DATA_W] = 1'b1;                  // 2^1024

        vt[0] = mk(5, m0);
        vt[1] = mk({1'b0, m0} + 5, m0);
        vt[2] = mk({1'b0, m0}, m0);
        vt[3] = mk({m0, 1'b0} - 1, m0);
        vt[4] = mk(t1, m0);
        vt[5] = mk({1'b0, m0} - 1, m0);
        vt[6] = mk({1'b0, r}, mr);
        vt[7] = mk({1'b0, mr} + {1'b0, r}, mr);
        vt[8] = mk({1'b0, mr} + {1'b0, mr} - 1, mr);
        vt[9] = mk({1'b0, rnd_wide()} & {1'b0, mr} , mr);

        // Reset state
        repeat (3) @(negedge clk);
        chk_wide("reset_result", result, '0);
        chk_int("reset_done", int'(done), 0);
        chk_int("reset_busy", int'(busy), 0);
        resetn = 1'b0;

        for (int i = 0; i < 10; i++) run_job(vt[i], $sformatf("vec%0d", i), -1, 1'b0);

        // start while busy and start during the done cycle are both ignored
        run_job(vt[1], "poke", 3, 1'b1);
        quiet("poke", 15);
        run_job(vt[4], "after_poke", -1, 1'b0);

        // Reset during SUB cycle 4 aborts the job and clears result
        @(negedge clk);
        in_t  = vt[6].t;
        in_m  = vt[6].m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        chk_wide("abort_result", result, '0);
        chk_int("abort_busy", int'(busy), 0);
        chk_int("abort_done", int'(done), 0);
        quiet("abort", 15);
        run_job(vt[7], "after_abort", -1, 1'b0);

`ifdef FINAL_REDUCE_CHECK_EN
        run_job(mk({m0, 1'b0}, m0), "err_2m", -1, 1'b0);
        run_job(mk({m0, 1'b0} - 1, m0), "err_2m_minus1", -1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
